// File: rtl/tri_raster_writer.sv
// Triangle rasterizer feeding the framebuffer SRAM write port: bbox scan, edge tests, valid/ready writes.
// Optional BACKFACE_CULL_EN drops triangles with negative orientation before scanning.
module tri_raster_writer #(
    parameter int unsigned H_RES = 640,
    parameter int unsigned V_RES = 480
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        start,
    input  logic [9:0]  p1x,
    input  logic [9:0]  p1y,
    input  logic [9:0]  p2x,
    input  logic [9:0]  p2y,
    input  logic [9:0]  p3x,
    input  logic [9:0]  p3y,
    input  logic [5:0]  color,
    output logic        busy,
    output logic        done,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [17:0] wr_addr,
    output logic [15:0] wr_data,
    output logic [1:0]  wr_be,
    output logic [18:0] pix_count
);

    localparam int unsigned CW = 10;
    localparam int unsigned EW = 23;
    localparam logic [CW-1:0] X_LIM = CW'(H_RES - 1);
    localparam logic [CW-1:0] Y_LIM = CW'(V_RES - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SCAN, S_FLUSH, S_DONE} state_t;

    state_t              state, state_n;
    logic [CW-1:0]       q1x, q1y, q2x, q2y, q3x, q3y;
    logic [CW-1:0]       q1x_n, q1y_n, q2x_n, q2y_n, q3x_n, q3y_n;
    logic [5:0]          col, col_n;
    logic [CW-1:0]       xmin, xmax, ymax, x, y;
    logic [CW-1:0]       xmin_n, xmax_n, ymax_n, x_n, y_n;
    logic signed [EW-1:0] orient, orient_n;
    logic                busy_n, done_n, wr_valid_n;
    logic [17:0]         wr_addr_n;
    logic [15:0]         wr_data_n;
    logic [1:0]          wr_be_n;
    logic [18:0]         pix_count_n;

    logic [CW-1:0]       bx_min, bx_max, by_min, by_max;
    logic signed [EW-1:0] o_c, e1_c, e2_c, e3_c;
    logic                inside_c, accept_c, degen_c;

    // E(a,b,c) with 11-bit signed differences and 22-bit products; cannot overflow.
    function automatic logic signed [EW-1:0] edge_fn(
        input logic [CW-1:0] ax, input logic [CW-1:0] ay,
        input logic [CW-1:0] bx, input logic [CW-1:0] by,
        input logic [CW-1:0] cx, input logic [CW-1:0] cy);
        logic signed [10:0] dax, day, dbx, dby;
        logic signed [21:0] m0, m1;
        dax = $signed({1'b0, ax}) - $signed({1'b0, cx});
        day = $signed({1'b0, ay}) - $signed({1'b0, cy});
        dbx = $signed({1'b0, bx}) - $signed({1'b0, cx});
        dby = $signed({1'b0, by}) - $signed({1'b0, cy});
        m0  = 22'(dax) * 22'(dby);
        m1  = 22'(dbx) * 22'(day);
        return EW'(m0) - EW'(m1);
    endfunction

    function automatic logic [CW-1:0] min3(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                           input logic [CW-1:0] c);
        logic [CW-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [CW-1:0] max3(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                           input logic [CW-1:0] c);
        logic [CW-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic nonneg(input logic signed [EW-1:0] v);
        return !v[EW-1];
    endfunction

    function automatic logic nonpos(input logic signed [EW-1:0] v);
        return v[EW-1] || (v == '0);
    endfunction

    // Geometry evaluated from the latched vertices and the current scan position.
    always_comb begin
        bx_min   = min3(q1x, q2x, q3x);
        bx_max   = max3(q1x, q2x, q3x);
        by_min   = min3(q1y, q2y, q3y);
        by_max   = max3(q1y, q2y, q3y);
        o_c      = edge_fn(q1x, q1y, q2x, q2y, q3x, q3y);
        e1_c     = edge_fn(q1x, q1y, q2x, q2y, x, y);
        e2_c     = edge_fn(q2x, q2y, q3x, q3y, x, y);
        e3_c     = edge_fn(q3x, q3y, q1x, q1y, x, y);
        inside_c = (nonneg(orient) && (orient != '0) && nonneg(e1_c) && nonneg(e2_c) && nonneg(e3_c))
                || (orient[EW-1] && nonpos(e1_c) && nonpos(e2_c) && nonpos(e3_c));
        accept_c = wr_valid && wr_ready;
`ifdef BACKFACE_CULL_EN
        degen_c  = (o_c == '0) || o_c[EW-1] || (bx_min > X_LIM) || (by_min > Y_LIM);
`else
        degen_c  = (o_c == '0) || (bx_min > X_LIM) || (by_min > Y_LIM);
`endif
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_n     = state;
        q1x_n = q1x; q1y_n = q1y; q2x_n = q2x; q2y_n = q2y; q3x_n = q3x; q3y_n = q3y;
        col_n       = col;
        xmin_n      = xmin;
        xmax_n      = xmax;
        ymax_n      = ymax;
        x_n         = x;
        y_n         = y;
        orient_n    = orient;
        busy_n      = busy;
        done_n      = 1'b0;
        wr_valid_n  = wr_valid && !wr_ready;
        wr_addr_n   = wr_addr;
        wr_data_n   = wr_data;
        wr_be_n     = wr_be;
        pix_count_n = pix_count + 19'(accept_c);

        case (state)
            S_IDLE: begin
                if (start) begin
                    q1x_n = p1x; q1y_n = p1y; q2x_n = p2x; q2y_n = p2y; q3x_n = p3x; q3y_n = p3y;
                    col_n       = color;
                    pix_count_n = '0;
                    busy_n      = 1'b1;
                    state_n     = S_SETUP;
                end
            end
            S_SETUP: begin
                xmin_n   = bx_min;
                xmax_n   = (bx_max > X_LIM) ? X_LIM : bx_max;
                ymax_n   = (by_max > Y_LIM) ? Y_LIM : by_max;
                orient_n = o_c;
                x_n      = bx_min;
                y_n      = by_min;
                if (degen_c) begin
                    done_n  = 1'b1;
                    state_n = S_DONE;
                end else begin
                    state_n = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!wr_valid || wr_ready) begin
                    wr_valid_n = inside_c;
                    if (inside_c) begin
                        wr_addr_n = {y[8:0], x[9:1]};
                        wr_data_n = {2'b00, col, 2'b00, col};
                        wr_be_n   = x[0] ? 2'b10 : 2'b01;
                    end
                    if (x == xmax) begin
                        x_n = xmin;
                        if (y == ymax) state_n = S_FLUSH;
                        else           y_n = y + 1'b1;
                    end else begin
                        x_n = x + 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (!wr_valid || wr_ready) begin
                    done_n  = 1'b1;
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            q1x <= '0; q1y <= '0; q2x <= '0; q2y <= '0; q3x <= '0; q3y <= '0;
            col       <= '0;
            xmin      <= '0;
            xmax      <= '0;
            ymax      <= '0;
            x         <= '0;
            y         <= '0;
            orient    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_be     <= '0;
            pix_count <= '0;
        end else begin
            state     <= state_n;
            q1x <= q1x_n; q1y <= q1y_n; q2x <= q2x_n; q2y <= q2y_n; q3x <= q3x_n; q3y <= q3y_n;
            col       <= col_n;
            xmin      <= xmin_n;
            xmax      <= xmax_n;
            ymax      <= ymax_n;
            x         <= x_n;
            y         <= y_n;
            orient    <= orient_n;
            busy      <= busy_n;
            done      <= done_n;
            wr_valid  <= wr_valid_n;
            wr_addr   <= wr_addr_n;
            wr_data   <= wr_data_n;
            wr_be     <= wr_be_n;
            pix_count <= pix_count_n;
        end
    end

endmodule

// File: tb/tb_tri_raster_writer.sv
// Scoreboard bench for tri_raster_writer: a reference rasterizer queues expected writes, accepted writes are popped and compared.
module tb_tri_raster_writer;

    logic        CLOCK_50;
    logic        reset;
    logic        start;
    logic [9:0]  p1x, p1y, p2x, p2y, p3x, p3y;
    logic [5:0]  color;
    logic        busy, done, wr_valid, wr_ready;
    logic [17:0] wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic [18:0] pix_count;

    typedef struct packed {
        logic [17:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    tri_raster_writer dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start),
        .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y), .p3x(p3x), .p3y(p3y),
        .color(color), .busy(busy), .done(done), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .pix_count(pix_count)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic int edge_m(int ax, int ay, int bx, int by, int cx, int cy);
        return (ax - cx) * (by - cy) - (bx - cx) * (ay - cy);
    endfunction

    // Reference rasterizer: pushes every covered pixel in raster order.
    task automatic model_push(input int ax, input int ay, input int bx, input int by,
                              input int cx, input int cy, input logic [5:0] col, output int n);
        int o, xmn, xmx, ymn, ymx, e1, e2, e3;
        logic [9:0] xv, yv;
        wr_t w;
        n = 0;
        o = edge_m(ax, ay, bx, by, cx, cy);
        xmn = (ax < bx) ? ax : bx; xmn = (xmn < cx) ? xmn : cx;
        ymn = (ay < by) ? ay : by; ymn = (ymn < cy) ? ymn : cy;
        xmx = (ax > bx) ? ax : bx; xmx = (xmx > cx) ? xmx : cx;
        ymx = (ay > by) ? ay : by; ymx = (ymx > cy) ? ymx : cy;
        if (xmx > 639) xmx = 639;
        if (ymx > 479) ymx = 479;
`ifdef BACKFACE_CULL_EN
        if (o < 0) return;
`endif
        if (o == 0 || xmn > 639 || ymn > 479) return;
        for (int yy = ymn; yy <= ymx; yy++) begin
            for (int xx = xmn; xx <= xmx; xx++) begin
                e1 = edge_m(ax, ay, bx, by, xx, yy);
                e2 = edge_m(bx, by, cx, cy, xx, yy);
                e3 = edge_m(cx, cy, ax, ay, xx, yy);
                if ((o > 0 && e1 >= 0 && e2 >= 0 && e3 >= 0) ||
                    (o < 0 && e1 <= 0 && e2 <= 0 && e3 <= 0)) begin
                    xv = 10'(xx);
                    yv = 10'(yy);
                    w.addr = {yv[8:0], xv[9:1]};
                    w.data = {2'b00, col, 2'b00, col};
                    w.be   = xv[0] ? 2'b10 : 2'b01;
                    exp_q.push_back(w);
                    n++;
                end
            end
        end
    endtask

    // Issue one triangle and consume its writes against the scoreboard.
    task automatic draw(input int ax, input int ay, input int bx, input int by, input int cx, input int cy,
                        input logic [5:0] col, input int stall, input int limit, input bit abort,
                        output int writes, output int done_cyc, output int done_cnt);
        int  n_exp, stall_left;
        bit  prev_v, prev_r, finished;
        wr_t prev, cur, e;
        int  px;
        model_push(ax, ay, bx, by, cx, cy, col, n_exp);
        @(negedge CLOCK_50);
        p1x = 10'(ax); p1y = 10'(ay); p2x = 10'(bx); p2y = 10'(by); p3x = 10'(cx); p3y = 10'(cy);
        color = col; start = 1'b1; wr_ready = 1'b1;
        writes = 0; done_cyc = -1; done_cnt = 0; prev_v = 0; prev_r = 1; prev = '0;
        stall_left = stall; finished = 0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge CLOCK_50);
            start = 1'b0;
            if (wr_valid && stall_left > 0) begin
                wr_ready = 1'b0;
                stall_left--;
            end else begin
                wr_ready = 1'b1;
            end
            cur = {wr_addr, wr_data, wr_be};
            if (prev_v && !prev_r) begin
                n_checks++;
                if (!wr_valid || cur !== prev) begin
                    n_fail++;
                    $display("FAIL hold_stable: valid=%0b out=%h required valid=1 out=%h", wr_valid, cur, prev);
                end
            end
            if (wr_valid && wr_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_write: got %h with no expected write pending", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        n_fail++;
                        $display("FAIL write_match: got addr=%h data=%h be=%b required addr=%h data=%h be=%b",
                                 wr_addr, wr_data, wr_be, e.addr, e.data, e.be);
                    end
                end
                px = int'(wr_addr[8:0]) * 2 + int'(wr_be[1]);
                n_checks++;
                if (px > 639 || wr_be == 2'b00 || wr_be == 2'b11) begin
                    n_fail++;
                    $display("FAIL write_x_range: x=%0d be=%b required x<=639 single-byte be", px, wr_be);
                end
                writes++;
            end
            prev_v = wr_valid; prev_r = wr_ready; prev = cur;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (done_cyc >= 0 && k > done_cyc && !busy) begin
                finished = 1;
                break;
            end
        end
        wr_ready = 1'b1;
        if (abort) return;
        n_checks++;
        if (!finished) begin
            n_fail++;
            $display("FAIL timeout: triangle not finished in %0d cycles, required done then busy low", limit);
        end
        n_checks++;
        if (exp_q.size() != 0 || writes != n_exp) begin
            n_fail++;
            $display("FAIL write_count: got %0d writes, %0d still pending, required %0d", writes, exp_q.size(), n_exp);
        end
        n_checks++;
        if (pix_count !== 19'(n_exp)) begin
            n_fail++;
            $display("FAIL pix_count: got %0d required %0d", pix_count, n_exp);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        n_checks++;
        if ({busy, done, wr_valid, wr_addr, wr_data, wr_be, pix_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%0b done=%0b valid=%0b addr=%h data=%h be=%b cnt=%0d required all 0",
                     busy, done, wr_valid, wr_addr, wr_data, wr_be, pix_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int w, dc, dn;
        draw(0, 0, 3, 0, 0, 3, 6'h03, 0, 200, 0, w, dc, dn);
        n_checks++;
        if (w != 10 || dn != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic: writes=%0d done_pulses=%0d busy=%0b required 10 1 0", w, dn, busy);
        end
    endtask

    task automatic test_winding();
        int w, dc, dn, req;
`ifdef BACKFACE_CULL_EN
        req = 0;
`else
        req = 10;
`endif
        draw(0, 0, 0, 3, 3, 0, 6'h03, 0, 200, 0, w, dc, dn);
        n_checks++;
        if (w != req || dn != 1) begin
            n_fail++;
            $display("FAIL winding: writes=%0d done_pulses=%0d required %0d 1", w, dn, req);
        end
    endtask

    task automatic test_degenerate();
        int w, dc, dn;
        draw(10, 10, 20, 20, 30, 30, 6'h15, 0, 50, 0, w, dc, dn);
        n_checks++;
        if (w != 0 || dc != 2 || dn != 1) begin
            n_fail++;
            $display("FAIL degenerate: writes=%0d done_cycle=%0d pulses=%0d required 0 2 1", w, dc, dn);
        end
    endtask

    task automatic test_stall();
        int w, dc, dn;
        draw(0, 0, 3, 0, 0, 3, 6'h03, 5, 200, 0, w, dc, dn);
        n_checks++;
        if (w != 10 || dn != 1) begin
            n_fail++;
            $display("FAIL stall: writes=%0d done_pulses=%0d required 10 1", w, dn);
        end
    endtask

    task automatic test_clip();
        int w, dc, dn;
        draw(600, 0, 700, 0, 600, 100, 6'h3F, 0, 6000, 0, w, dc, dn);
        n_checks++;
        if (w == 0 || dn != 1) begin
            n_fail++;
            $display("FAIL clip: writes=%0d done_pulses=%0d required >0 1", w, dn);
        end
    endtask

    task automatic test_reset_midscan();
        int w, dc, dn;
        draw(80, 470, 80, 352, 242, 352, 6'h2A, 0, 300, 1, w, dc, dn);
        n_checks++;
        if (!busy || pix_count == 0) begin
            n_fail++;
            $display("FAIL midscan_setup: busy=%0b cnt=%0d required busy=1 cnt>0 before reset", busy, pix_count);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (wr_valid !== 1'b0 || busy !== 1'b0 || pix_count !== '0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%0b busy=%0b cnt=%0d required 0 0 0", wr_valid, busy, pix_count);
        end
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge CLOCK_50);
        n_checks++;
        if (wr_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: valid=%0b busy=%0b required 0 0", wr_valid, busy);
        end
        draw(0, 0, 3, 0, 0, 3, 6'h2A, 0, 200, 0, w, dc, dn);
        n_checks++;
        if (w != 10 || dn != 1) begin
            n_fail++;
            $display("FAIL redraw: writes=%0d done_pulses=%0d required 10 1", w, dn);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; wr_ready = 1'b1; color = '0;
        p1x = '0; p1y = '0; p2x = '0; p2y = '0; p3x = '0; p3y = '0;
        test_reset();
        test_basic();
        test_winding();
        test_degenerate();
        test_stall();
        test_clip();
        test_reset_midscan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tri_raster_writer.md
Name: tri_raster_writer

Overview:
- Triangle rasterizer that sits directly upstream of the SRAM write port of the framebuffer arbiter.
- Latches three screen-space vertices and a colour, then walks the clamped bounding box in raster order.
- Tests each pixel with the three edge functions and issues one SRAM write request per covered pixel over a valid/ready handshake.
- Framebuffer format: 640x480, 6-bit RGB (2:2:2), two pixels per 16-bit SRAM word.

Parameters:
- H_RES, 640, visible width; bounding box x clamped to H_RES-1.
- V_RES, 480, visible height; bounding box y clamped to V_RES-1.

Ports:
- CLOCK_50  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  draw request; sampled only in IDLE.
- p1x,p1y,p2x,p2y,p3x,p3y  input  10 each  vertex coordinates, unsigned.
- color  input  6  {B[1:0],G[1:0],R[1:0]}, latched with start.
- busy  output  1  high from start accepted until done pulse inclusive.
- done  output  1  one-cycle pulse at end of triangle.
- wr_valid  output  1  write request valid.
- wr_ready  input  1  arbiter accepts when wr_valid&&wr_ready at a clock edge.
- wr_addr  output  18  {y[8:0], x[9:1]}.
- wr_data  output  16  {2'b00,color,2'b00,color}; byte replicated.
- wr_be  output  2  x[0]=0 -> 2'b01 (low byte); x[0]=1 -> 2'b10.
- pix_count  output  19  writes accepted for the current/last triangle.

Behaviour:
- Reset (async): state IDLE; busy=0, done=0, wr_valid=0, wr_addr=0, wr_data=0, wr_be=0, pix_count=0.
- A reset mid-triangle abandons it immediately; no further requests are issued.
- FSM states: IDLE, SETUP, SCAN, FLUSH, DONE.
- IDLE:
  - On start=1: latch vertices and colour, clear pix_count, busy=1, go to SETUP.
  - start outside IDLE is ignored.
- SETUP (1 cycle):
  - Register bbox: xmin=min(px), xmax=min(max(px),H_RES-1), same for y with V_RES-1.
  - Register orientation o = E(p1,p2,p3).
  - E(a,b,c) = (a.x-c.x)*(b.y-c.y) - (b.x-c.x)*(a.y-c.y), evaluated as signed with 11-bit differences and 22-bit products; no overflow possible.
  - If o==0 (degenerate), or xmin>H_RES-1, or ymin>V_RES-1: go to DONE.
  - Otherwise set (x,y)=(xmin,ymin) and go to SCAN.
- SCAN, one pixel per cycle when the output register is empty or being accepted this cycle:
  - Compute e1=E(p1,p2,P), e2=E(p2,p3,P), e3=E(p3,p1,P) for P=(x,y).
  - Inside when o>0 and all e>=0, or when o<0 and all e<=0. Edges and vertices count as inside.
  - If inside: load wr_addr/wr_data/wr_be and set wr_valid=1.
  - Advance: x++; at x==xmax, x=xmin and y++. After (xmax,ymax), go to FLUSH.
  - When the output register is full and not accepted, (x,y) holds. No pixel is skipped or duplicated.
- Handshake rules:
  - wr_valid, once high, stays high with addr/data/be stable until accepted.
  - Acceptance increments pix_count.
  - An accept and a new load in the same cycle is legal (back-to-back throughput).
- FLUSH: wait until wr_valid=0 or it is accepted, then go to DONE.
- DONE: done=1 for one cycle, busy=0 in the following cycle, go to IDLE.
- Latency:
  - Degenerate triangle: done high in the 2nd cycle after start sampled.
  - First write candidate: (xmin,ymin), registered 2 cycles after start.

Optional Feature:
- Macro BACKFACE_CULL_EN.
- When defined: a triangle with o<0 goes from SETUP to DONE with no writes (pix_count=0).
- When undefined: both windings are filled identically.

Test Plan:
- Triangle (0,0),(3,0),(0,3), colour 6'h03, wr_ready=1:
  - Exactly 10 writes, pix_count=10.
  - First write wr_addr=0, wr_be=01, wr_data=16'h0303.
  - Second write wr_addr=0, wr_be=10.
  - done pulses once; busy low afterwards.
- Same triangle with vertex order (0,0),(0,3),(3,0) (o<0): 10 identical writes without BACKFACE_CULL_EN; 0 writes and done with it.
- Degenerate (10,10),(20,20),(30,30): no wr_valid; done high 2 cycles after start.
- First triangle with wr_ready held low 5 cycles after the first wr_valid: outputs stable throughout, total writes still 10, no duplicate addresses.
- Triangle (600,0),(700,0),(600,100):
  - No write with x>639; every write has x in 600..639 and y<=100.
  - pix_count matches a bench model that counts covered pixels clipped to x<=639.
- Triangle (80,470),(80,352),(242,352) with reset asserted mid-scan:
  - wr_valid, busy and pix_count go to 0 asynchronously.
  - A new start after reset release draws a fresh triangle correctly.
